// File: rtl/stream_egress_fifo_if.sv
// Valid/ready stream bundle used on both sides of the egress FIFO.
// master drives data/valid and samples ready; slave does the reverse.
interface stream_egress_fifo_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/stream_egress_fifo.sv
// First-word-fall-through elastic buffer placed after one switch output port.
// Optional statistics counters are enabled by defining IO_FIFO_STATS_EN.
module stream_egress_fifo #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  stream_egress_fifo_if.slave      in_s,
  stream_egress_fifo_if.master     out_m,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full
`ifdef IO_FIFO_STATS_EN
  ,
  input  logic                     stat_clr,
  output logic [31:0]              stat_push_cnt,
  output logic [31:0]              stat_pop_cnt,
  output logic [$clog2(DEPTH):0]   stat_max_occ
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      cnt;
  logic                  rst_q;
  logic                  push;
  logic                  pop;

  // Ready depends only on registered state, so no out_ready -> in_ready path exists.
  assign in_s.ready  = (cnt != FULL_CNT) && !rst_q;
  assign out_m.valid = (cnt != '0);
  assign out_m.data  = out_m.valid ? mem[rd_ptr] : '0;
  assign count       = cnt;
  assign almost_full = (cnt >= AFULL_CNT);

  assign push = in_s.valid && in_s.ready;
  assign pop  = out_m.valid && out_m.ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: the storage array has no reset; cnt/out_valid gate every read, so
  // stale contents are never observable and the array maps to plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem[wr_ptr] <= in_s.data;
  end

`ifdef IO_FIFO_STATS_EN
  // Clear wins over a coincident push/pop; flush leaves the statistics alone.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_push_cnt <= '0;
      stat_pop_cnt  <= '0;
      stat_max_occ  <= '0;
    end else begin
      if (push) stat_push_cnt <= stat_push_cnt + 32'd1;
      if (pop)  stat_pop_cnt  <= stat_pop_cnt + 32'd1;
      if (cnt > stat_max_occ) stat_max_occ <= cnt;
    end
  end
`endif

endmodule

// File: tb/tb_stream_egress_fifo.sv
// Scoreboard bench for stream_egress_fifo; stats scenario compiled only when
// IO_FIFO_STATS_EN is defined.
module tb_stream_egress_fifo;

  localparam int DATA_WIDTH   = 32;
  localparam int DEPTH        = 8;
  localparam int AFULL_THRESH = 6;
  localparam int CNT_W        = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [CNT_W-1:0] count;
  logic             almost_full;
`ifdef IO_FIFO_STATS_EN
  logic             stat_clr;
  logic [31:0]      stat_push_cnt;
  logic [31:0]      stat_pop_cnt;
  logic [CNT_W-1:0] stat_max_occ;
`endif

  stream_egress_fifo_if #(.DATA_WIDTH(DATA_WIDTH)) in_if ();
  stream_egress_fifo_if #(.DATA_WIDTH(DATA_WIDTH)) out_if ();

  stream_egress_fifo #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH       (DEPTH),
    .AFULL_THRESH(AFULL_THRESH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_s       (in_if),
    .out_m      (out_if),
    .count      (count),
    .almost_full(almost_full)
`ifdef IO_FIFO_STATS_EN
    ,
    .stat_clr     (stat_clr),
    .stat_push_cnt(stat_push_cnt),
    .stat_pop_cnt (stat_pop_cnt),
    .stat_max_occ (stat_max_occ)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of words the FIFO should hold, plus reset-release flag.
  logic [DATA_WIDTH-1:0] exp_q[$];
  logic                  m_rstq = 1'b1;

  function automatic logic [CNT_W-1:0] exp_count();
    return CNT_W'(exp_q.size());
  endfunction

  function automatic logic exp_ready();
    return (exp_q.size() != DEPTH) && !m_rstq;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] exp_head();
    return (exp_q.size() != 0) ? exp_q[0] : '0;
  endfunction

  // One clock: drive inputs, advance the model using pre-edge state, sample #1 after the edge.
  task automatic step(input logic iv, input logic [DATA_WIDTH-1:0] id,
                      input logic ordy, input logic fl, input logic rs);
    logic m_push;
    logic m_pop;
    m_push = iv && exp_ready();
    m_pop  = (exp_q.size() != 0) && ordy;
    in_if.valid  = iv;
    in_if.data   = id;
    out_if.ready = ordy;
    flush        = fl;
    rst          = rs;
    @(posedge clk);
    #1;
    if (rs || fl) begin
      exp_q.delete();
    end else begin
      if (m_pop)  void'(exp_q.pop_front());
      if (m_push) exp_q.push_back(id);
    end
    m_rstq = rs;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b0, 1'b0, (i < 2));
      checks++;
      if (in_if.ready !== exp_ready()) begin
        errors++;
        $display("FAIL reset_in_ready cyc=%0d got=%b exp=%b", i, in_if.ready, exp_ready());
      end
      checks++;
      if (out_if.valid !== 1'b0 || count !== '0 || out_if.data !== '0 || almost_full !== 1'b0) begin
        errors++;
        $display("FAIL reset_state cyc=%0d valid=%b count=%0d data=%h af=%b exp 0/0/0/0",
                 i, out_if.valid, count, out_if.data, almost_full);
      end
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, DATA_WIDTH'(32'hA0 + i), 1'b0, 1'b0, 1'b0);
      checks++;
      if (count !== exp_count() || almost_full !== (exp_q.size() >= AFULL_THRESH)
          || in_if.ready !== exp_ready()) begin
        errors++;
        $display("FAIL fill cyc=%0d count=%0d af=%b rdy=%b exp %0d/%b/%b", i, count,
                 almost_full, in_if.ready, exp_count(), exp_q.size() >= AFULL_THRESH, exp_ready());
      end
      checks++;
      if (out_if.data !== exp_head() || out_if.data !== 32'hA0) begin
        errors++;
        $display("FAIL fill_head_hold cyc=%0d got=%h exp=%h", i, out_if.data, 32'hA0);
      end
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_if.valid !== 1'b1 || out_if.data !== DATA_WIDTH'(32'hA0 + i)) begin
        errors++;
        $display("FAIL drain_word idx=%0d valid=%b got=%h exp=%h", i, out_if.valid,
                 out_if.data, 32'hA0 + i);
      end
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (count !== exp_count() || out_if.data !== exp_head()) begin
        errors++;
        $display("FAIL drain_state idx=%0d count=%0d data=%h exp %0d/%h", i, count,
                 out_if.data, exp_count(), exp_head());
      end
    end
    checks++;
    if (out_if.valid !== 1'b0 || out_if.data !== '0 || count !== '0) begin
      errors++;
      $display("FAIL drain_empty valid=%b data=%h count=%0d exp 0/0/0", out_if.valid,
               out_if.data, count);
    end
  endtask

  task automatic test_stream_wrap();
    for (int i = 0; i < 32; i++) begin
      step(1'b1, DATA_WIDTH'(32'h100 + i), 1'b1, 1'b0, 1'b0);
      checks++;
      if (count !== CNT_W'(1) || out_if.valid !== 1'b1 || out_if.data !== exp_head()
          || out_if.data !== DATA_WIDTH'(32'h100 + i)) begin
        errors++;
        $display("FAIL stream idx=%0d count=%0d valid=%b data=%h exp 1/1/%h", i, count,
                 out_if.valid, out_if.data, 32'h100 + i);
      end
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (count !== '0 || out_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_end count=%0d valid=%b exp 0/0", count, out_if.valid);
    end
  endtask

  task automatic load_five(input logic [DATA_WIDTH-1:0] base);
    for (int i = 0; i < 5; i++) step(1'b1, base + DATA_WIDTH'(i), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    load_five(32'hC0);
    checks++;
    if (count !== CNT_W'(5) || out_if.data !== 32'hC0) begin
      errors++;
      $display("FAIL flush_load count=%0d data=%h exp 5/c0", count, out_if.data);
    end
    step(1'b1, 32'hBEEF, 1'b1, 1'b1, 1'b0);
    checks++;
    if (count !== '0 || out_if.valid !== 1'b0 || out_if.data !== '0 || in_if.ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_clear count=%0d valid=%b data=%h rdy=%b exp 0/0/0/1", count,
               out_if.valid, out_if.data, in_if.ready);
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (out_if.valid !== 1'b0 || count !== exp_count()) begin
      errors++;
      $display("FAIL flush_no_beef valid=%b count=%0d exp 0/0", out_if.valid, count);
    end
  endtask

  task automatic test_reset_mid();
    load_five(32'hD0);
    step(1'b1, 32'hBEEF, 1'b1, 1'b0, 1'b1);
    checks++;
    if (count !== '0 || out_if.valid !== 1'b0 || out_if.data !== '0 || in_if.ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_clear count=%0d valid=%b data=%h rdy=%b exp 0/0/0/0", count,
               out_if.valid, out_if.data, in_if.ready);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 32'hE0 + DATA_WIDTH'(i), 1'b0, 1'b0, 1'b0);
      checks++;
      if (in_if.ready !== exp_ready() || count !== exp_count() || out_if.data !== exp_head()) begin
        errors++;
        $display("FAIL rstmid_release cyc=%0d rdy=%b count=%0d data=%h exp %b/%0d/%h", i,
                 in_if.ready, count, out_if.data, exp_ready(), exp_count(), exp_head());
      end
    end
    checks++;
    if (out_if.data !== 32'hE1 || count !== CNT_W'(1)) begin
      errors++;
      $display("FAIL rstmid_first_word data=%h count=%0d exp e1/1", out_if.data, count);
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

`ifdef IO_FIFO_STATS_EN
  task automatic test_stats();
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 32'h200 + DATA_WIDTH'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 32'h205 + DATA_WIDTH'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (stat_push_cnt !== 32'd10 || stat_pop_cnt !== 32'd7 || stat_max_occ !== CNT_W'(5)) begin
      errors++;
      $display("FAIL stats_counts push=%0d pop=%0d max=%0d exp 10/7/5", stat_push_cnt,
               stat_pop_cnt, stat_max_occ);
    end
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (stat_push_cnt !== 32'd10 || stat_pop_cnt !== 32'd7) begin
      errors++;
      $display("FAIL stats_flush_keep push=%0d pop=%0d exp 10/7", stat_push_cnt, stat_pop_cnt);
    end
    stat_clr = 1'b1;
    step(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
    stat_clr = 1'b0;
    checks++;
    if (stat_push_cnt !== '0 || stat_pop_cnt !== '0 || stat_max_occ !== '0) begin
      errors++;
      $display("FAIL stats_clr push=%0d pop=%0d max=%0d exp 0/0/0", stat_push_cnt,
               stat_pop_cnt, stat_max_occ);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    out_if.ready = 1'b0;
    flush        = 1'b0;
    rst          = 1'b1;
`ifdef IO_FIFO_STATS_EN
    stat_clr     = 1'b0;
`endif
    // First edge only establishes the reset flag; checks start after it.
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    test_reset();
    test_fill();
    test_drain();
    test_stream_wrap();
    test_flush();
    test_reset_mid();
`ifdef IO_FIFO_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_egress_fifo.md
Name: stream_egress_fifo

Overview:
- Per-port elastic buffer placed directly downstream of each output port of the 4x4 streaming I/O switch.
- Absorbs backpressure bursts between the switch output and the consumer.
- Simplified AXI-stream valid/ready handshake on both sides.
- First-word-fall-through; one instance per switch output, four per switch.

Parameters:
DATA_WIDTH, 32, width of stream data word
DEPTH, 8, number of entries; power of 2, minimum 2
AFULL_THRESH, 6, occupancy at or above which almost_full asserts; range 1..DEPTH

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  synchronous clear of contents; pulse
in_data  input  DATA_WIDTH  write data from switch out_data_N
in_valid  input  1  write request from switch out_valid_N
in_ready  output  1  FIFO can accept; drives switch out_ready_N
out_data  output  DATA_WIDTH  head-of-FIFO data
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts head word
count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH
almost_full  output  1  count >= AFULL_THRESH

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Storage:
  - DEPTH x DATA_WIDTH register array.
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - Registered occupancy counter cnt is log2(DEPTH)+1 bits.
- Push and pop:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- in_ready:
  - Equals (cnt != DEPTH) & ~rst_q.
  - rst_q is a register set by rst and cleared the first cycle after rst deasserts.
  - in_ready never depends combinationally on out_ready; there is no full-bypass.
- out_valid is (cnt != 0).
- out_data:
  - Equals mem[rd_ptr] when out_valid=1.
  - Forced to 0 when empty.
- count mirrors cnt. almost_full is (cnt >= AFULL_THRESH). Both are combinational from registers only.
- Latency:
  - A word pushed in cycle N appears on out_data/out_valid in cycle N+1.
  - Minimum latency is 1 cycle; there is no same-cycle in-to-out path.
- Throughput: 1 word/cycle sustained when neither side stalls.
- Occupancy update each cycle:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, with both pointers advancing.
  - neither: unchanged.
- Full (cnt=DEPTH):
  - in_ready=0.
  - A pop in that cycle frees one entry; in_ready rises the next cycle.
- Empty (cnt=0):
  - out_valid=0 and out_data=0; out_ready is ignored.
  - A push makes the word visible next cycle.
- Data stability: while out_valid=1 and out_ready=0, out_data and out_valid hold unchanged.
- Upstream protocol: the upstream side is expected to hold in_data stable while in_valid=1 and in_ready=0. The FIFO does not check this.
- flush:
  - Pointers and cnt are set to 0 on the next edge.
  - Any push or pop in the flush cycle is discarded.
  - in_ready is unaffected; it stays 1 because cnt becomes 0.
- rst:
  - Highest priority; identical to flush plus rst_q set.
  - Reset values: out_valid=0, out_data=0, count=0, almost_full=0, in_ready=0 while rst=1 and for 1 cycle after.
  - Memory contents are not reset.
  - Reset mid-transfer drops all stored words; no partial state survives.
- No state machine beyond the reset-release flag.
- Pointer/count arithmetic is unsigned modulo 2^width; cnt never exceeds DEPTH by construction.

Optional Feature:
- Macro: IO_FIFO_STATS_EN.
- When defined, adds these ports:
  - stat_clr input 1.
  - stat_push_cnt output 32.
  - stat_pop_cnt output 32.
  - stat_max_occ output log2(DEPTH)+1.
- Push and pop counters:
  - Increment on each push/pop and wrap at 2^32.
  - stat_max_occ tracks the highest cnt seen.
  - All three clear to 0 on rst or stat_clr.
  - flush does not clear them.
  - stat_clr coincident with a push/pop yields 0, not 1.
- When undefined: the ports and counters are absent, and the core behaviour is identical.

Test Plan:
- Reset release: rst high 3 cycles, then low.
  - Required: in_ready=0 through 1 cycle after release, then 1.
  - Required: out_valid=0, count=0, out_data=0 throughout.
- Fill to full, DEPTH=8, AFULL_THRESH=6: push 0xA0..0xA7 back-to-back with out_ready=0.
  - Required: almost_full=1 once count=6; in_ready=0 at count=8.
  - Required: a 9th in_valid word 0xA8 is not accepted.
- Drain order: after the fill, set out_ready=1.
  - Required: out_data sequence 0xA0..0xA7, one per cycle.
  - Required: out_valid=0 and out_data=0 after the 8th word; count steps 8->0.
- Streaming with wrap: continuous push and pop of 0x100..0x11F, both sides always ready.
  - Required: each word exits 1 cycle after entry; count stays 1; no loss across pointer wrap.
- Flush and reset mid-operation: hold 5 words, then assert flush together with in_valid=1 (0xBEEF) and out_ready=1.
  - Required next cycle: count=0, out_valid=0; 0xBEEF absent.
  - Repeat with rst instead of flush: same result, plus in_ready low as in the reset-release scenario.
- IO_FIFO_STATS_EN defined: 10 pushes, 7 pops, peak occupancy 5.
  - Required: stat_push_cnt=10, stat_pop_cnt=7, stat_max_occ=5.
  - Required: stat_clr asserted in the same cycle as a push yields all counters 0.
